// File: rtl/ddram_psctl_pkg.sv
// Shared definitions for the DQS phase-shift sequencer: op codes, FSM states,
// error bit positions and timer sizing.
package ddram_psctl_pkg;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_GOTO = 2'b10,
        OP_ZERO = 2'b11
    } ps_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10,
        ST_SETTLE    = 2'b11
    } ps_state_e;

    localparam int ERR_CLAMPED   = 0;
    localparam int ERR_TIMEOUT   = 1;
    localparam int ERR_LOCK_LOST = 2;

    // Counter width able to hold the larger of the settle and timeout reloads.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ddram_pstimer.sv
// Loadable down-counter shared by the settle delay and the psdone timeout.
// Holds at zero; expired_o is high whenever the count is zero.
module ddram_pstimer #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/ddram_psctl.sv
// DCM variable-phase-shift sequencer: turns multi-step move commands into
// single PSEN strobes, tracks the signed tap position and clamps it.
module ddram_psctl
    import ddram_psctl_pkg::*;
#(
    parameter int PS_BITS        = 10,
    parameter int MAX_STEPS      = 255,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [PS_BITS-1:0] cmd_arg,
    output logic               dcm_psen,
    output logic               dcm_psincdec,
    input  logic               dcm_psdone,
    input  logic               dcm_locked,
    output logic [PS_BITS-1:0] position,
    output logic               busy,
    output logic               done,
    output logic [2:0]         err
);

    // Two guard bits: position + unsigned arg can exceed the PS_BITS+1 signed range.
    localparam int EXT = PS_BITS + 2;
    localparam int TW  = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    // Timeout reload is two short so done lands TIMEOUT_CYCLES after the PSEN cycle.
    localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);
    localparam logic [TW-1:0] ST_LOAD = TW'((SETTLE_CYCLES >= 1) ? SETTLE_CYCLES - 1 : 0);
    localparam logic signed [EXT-1:0] MAX_EXT = EXT'(MAX_STEPS);
    localparam logic signed [EXT-1:0] MIN_EXT = -EXT'(MAX_STEPS);

    ps_state_e                  state_q, state_d;
    logic signed [PS_BITS-1:0]  position_q, position_d;
    logic signed [PS_BITS-1:0]  target_q, target_d;
    logic [2:0]                 err_q, err_d;
    logic                       done_q, done_d;
    logic                       armed_q;

    logic                       accept;
    logic                       tmr_load;
    logic [TW-1:0]              tmr_value;
    logic                       tmr_expired;
    logic signed [EXT-1:0]      pos_ext, arg_u, arg_s, raw_target, clamp_target;
    logic                       clamped;
    logic signed [PS_BITS-1:0]  pos_step;

    ddram_pstimer #(.W(TW)) u_timer (
        .clk_i     (sys_clk),
        .rst_n_i   (sys_rst_n),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            position_q <= '0;
            target_q   <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            target_q   <= target_d;
            err_q      <= err_d;
            done_q     <= done_d;
            armed_q    <= 1'b1;
        end
    end

    always_comb begin
        pos_ext = {{2{position_q[PS_BITS-1]}}, position_q};
        arg_u   = {2'b00, cmd_arg};
        arg_s   = {{2{cmd_arg[PS_BITS-1]}}, cmd_arg};
        unique case (ps_op_e'(cmd_op))
            OP_INC:  raw_target = pos_ext + arg_u;
            OP_DEC:  raw_target = pos_ext - arg_u;
            OP_GOTO: raw_target = arg_s;
            default: raw_target = '0;
        endcase
        clamped      = 1'b0;
        clamp_target = raw_target;
        if (raw_target > MAX_EXT) begin
            clamp_target = MAX_EXT;
            clamped      = 1'b1;
        end else if (raw_target < MIN_EXT) begin
            clamp_target = MIN_EXT;
            clamped      = 1'b1;
        end
        pos_step = (target_q > position_q) ? position_q + PS_BITS'(1)
                                           : position_q - PS_BITS'(1);
    end

    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        target_d   = target_q;
        err_d      = err_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = TO_LOAD;
        // An unlocked DCM has reset its phase, so the tap count restarts at zero.
        if (!dcm_locked) begin
            position_d = '0;
            if (state_q != ST_IDLE) begin
                err_d[ERR_LOCK_LOST] = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        target_d = clamp_target[PS_BITS-1:0];
                        err_d    = {2'b00, clamped};
                        if (clamp_target == pos_ext) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmr_load  = 1'b1;
                    tmr_value = TO_LOAD;
                    state_d   = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (dcm_psdone) begin
                        position_d = pos_step;
                        if (pos_step == target_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else if (SETTLE_CYCLES == 0) begin
                            state_d = ST_ISSUE;
                        end else begin
                            tmr_load  = 1'b1;
                            tmr_value = ST_LOAD;
                            state_d   = ST_SETTLE;
                        end
                    end else if (tmr_expired) begin
                        err_d[ERR_TIMEOUT] = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expired) begin
                        state_d = ST_ISSUE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready    = armed_q & dcm_locked & (state_q == ST_IDLE) & ~done_q;
        accept       = cmd_valid & cmd_ready;
        dcm_psen     = (state_q == ST_ISSUE) & dcm_locked;
        dcm_psincdec = dcm_psen & (target_q > position_q);
        busy         = (state_q != ST_IDLE) | done_q;
        done         = done_q;
        err          = err_q;
        position     = position_q;
    end

endmodule

// File: tb/tb_ddram_psctl.sv
// Directed bench for ddram_psctl with a behavioural DCM that answers each
// PSEN with psdone three cycles later.
module tb_ddram_psctl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [9:0] cmd_arg = '0;
    logic       dcm_psen;
    logic       dcm_psincdec;
    logic       dcm_psdone = 1'b0;
    logic       dcm_locked = 1'b1;
    logic [9:0] position;
    logic       busy;
    logic       done;
    logic [2:0] err;

    ddram_psctl #(
        .PS_BITS(10), .MAX_STEPS(255), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1023)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .dcm_psen     (dcm_psen),
        .dcm_psincdec (dcm_psincdec),
        .dcm_psdone   (dcm_psdone),
        .dcm_locked   (dcm_locked),
        .position     (position),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 sys_clk = ~sys_clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit dcm_auto = 1'b1;
    int dcm_cnt = 0;
    int psen_cnt = 0, up_cnt = 0, dn_cnt = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    int psen_cyc[8];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // DCM model plus monitor, both working on the falling edge.
    always @(negedge sys_clk) begin
        dcm_psdone = 1'b0;
        if (dcm_cnt > 0) begin
            dcm_cnt = dcm_cnt - 1;
            if (dcm_cnt == 0) dcm_psdone = 1'b1;
        end
        if (dcm_psen && dcm_auto) dcm_cnt = 3;
        if (dcm_psen) begin
            if (psen_cnt < 8) psen_cyc[psen_cnt] = cyc;
            psen_cnt = psen_cnt + 1;
            if (dcm_psincdec) up_cnt = up_cnt + 1;
            else dn_cnt = dn_cnt + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        psen_cnt = 0; up_cnt = 0; dn_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int i = 0; i < 8; i++) psen_cyc[i] = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [9:0] arg);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(negedge sys_clk);
        acc_cyc = cyc;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic report(input string name);
        $display("[TB] %s: pos=%0d err=%b psen=%0d up=%0d dn=%0d dones=%0d",
                 name, $signed(position), err, psen_cnt, up_cnt, dn_cnt, done_cnt);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; dcm_locked = 1'b1;
        repeat (2) tick();
        tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        tests_run++; if (dcm_psen !== 1'b0 || dcm_psincdec !== 1'b0) begin tests_failed++; $display("FAIL reset_psen: got %b%b want 00", dcm_psen, dcm_psincdec); end
        tests_run++; if (position !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 3'b000) begin tests_failed++; $display("FAIL reset_state: pos=%h busy=%b done=%b err=%b want 0", position, busy, done, err); end
        @(posedge sys_clk); #1; sys_rst_n = 1'b1;
        repeat (2) tick();
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
        report("reset");
    endtask

    task automatic test_inc();
        bit ok;
        clear_mon();
        send_cmd(2'b00, 10'd3);
        wait_done(100, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL inc_done_wait: got no done want done"); end
        repeat (12) tick();
        tests_run++; if (psen_cnt !== 3 || up_cnt !== 3) begin tests_failed++; $display("FAIL inc_psen: got psen=%0d up=%0d want 3/3", psen_cnt, up_cnt); end
        tests_run++; if (psen_cyc[0] !== acc_cyc + 1) begin tests_failed++; $display("FAIL inc_first_psen: got cycle %0d want %0d", psen_cyc[0], acc_cyc + 1); end
        tests_run++; if (psen_cyc[1] - psen_cyc[0] !== 8 || psen_cyc[2] - psen_cyc[1] !== 8) begin tests_failed++; $display("FAIL inc_spacing: got %0d,%0d want 8,8", psen_cyc[1] - psen_cyc[0], psen_cyc[2] - psen_cyc[1]); end
        tests_run++; if (done_cyc !== psen_cyc[2] + 4) begin tests_failed++; $display("FAIL inc_done_cycle: got %0d want %0d", done_cyc, psen_cyc[2] + 4); end
        tests_run++; if (position !== 10'd3 || err !== 3'b000 || done_cnt !== 1) begin tests_failed++; $display("FAIL inc_result: got pos=%0d err=%b dones=%0d want 3/000/1", $signed(position), err, done_cnt); end
        report("inc 3");
    endtask

    task automatic test_goto_neg();
        bit ok;
        clear_mon();
        send_cmd(2'b10, 10'h3FE);
        wait_done(200, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL goto_done_wait: got no done want done"); end
        repeat (12) tick();
        tests_run++; if (psen_cnt !== 5 || dn_cnt !== 5) begin tests_failed++; $display("FAIL goto_psen: got psen=%0d dn=%0d want 5/5", psen_cnt, dn_cnt); end
        tests_run++; if (position !== 10'h3FE || err !== 3'b000 || done_cnt !== 1) begin tests_failed++; $display("FAIL goto_result: got pos=%0d err=%b dones=%0d want -2/000/1", $signed(position), err, done_cnt); end
        report("goto -2");
    endtask

    task automatic test_zero_op();
        bit ok;
        clear_mon();
        send_cmd(2'b11, 10'd77);
        wait_done(100, ok);
        repeat (4) tick();
        tests_run++; if (!ok || psen_cnt !== 2 || up_cnt !== 2 || position !== 10'd0) begin tests_failed++; $display("FAIL zero_op: got done=%b psen=%0d up=%0d pos=%0d want 1/2/2/0", ok, psen_cnt, up_cnt, $signed(position)); end
        report("zero");
    endtask

    task automatic test_clamp();
        bit ok;
        clear_mon();
        send_cmd(2'b10, 10'd250);
        wait_done(3000, ok);
        repeat (4) tick();
        tests_run++; if (!ok || position !== 10'd250 || err !== 3'b000 || up_cnt !== 250) begin tests_failed++; $display("FAIL clamp_goto250: got done=%b pos=%0d err=%b up=%0d want 1/250/000/250", ok, $signed(position), err, up_cnt); end
        report("goto 250");
        clear_mon();
        send_cmd(2'b00, 10'd20);
        wait_done(200, ok);
        repeat (12) tick();
        tests_run++; if (!ok || psen_cnt !== 5 || up_cnt !== 5) begin tests_failed++; $display("FAIL clamp_steps: got done=%b psen=%0d up=%0d want 1/5/5", ok, psen_cnt, up_cnt); end
        tests_run++; if (position !== 10'd255 || err !== 3'b001 || done_cnt !== 1) begin tests_failed++; $display("FAIL clamp_result: got pos=%0d err=%b dones=%0d want 255/001/1", $signed(position), err, done_cnt); end
        report("inc 20");
    endtask

    task automatic test_timeout();
        bit ok;
        dcm_auto = 1'b0;
        clear_mon();
        send_cmd(2'b01, 10'd1);
        wait_done(1100, ok);
        repeat (3) tick();
        tests_run++; if (!ok || psen_cnt !== 1) begin tests_failed++; $display("FAIL timeout_wait: got done=%b psen=%0d want 1/1", ok, psen_cnt); end
        tests_run++; if (done_cyc - psen_cyc[0] !== 1023) begin tests_failed++; $display("FAIL timeout_latency: got %0d want 1023", done_cyc - psen_cyc[0]); end
        tests_run++; if (err !== 3'b010 || position !== 10'd255) begin tests_failed++; $display("FAIL timeout_result: got err=%b pos=%0d want 010/255", err, $signed(position)); end
        dcm_auto = 1'b1;
        report("dec 1 timeout");
    endtask

    task automatic test_zero_step();
        clear_mon();
        send_cmd(2'b10, 10'd255);
        tick();
        tests_run++; if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL zstep_n1: got done=%b busy=%b ready=%b want 1/1/0", done, busy, cmd_ready); end
        tests_run++; if (err !== 3'b000 || done_cyc !== acc_cyc + 1) begin tests_failed++; $display("FAIL zstep_err: got err=%b done_cyc=%0d want 000/%0d", err, done_cyc, acc_cyc + 1); end
        tick();
        tests_run++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || psen_cnt !== 0) begin tests_failed++; $display("FAIL zstep_n2: got done=%b busy=%b ready=%b psen=%0d want 0/0/1/0", done, busy, cmd_ready, psen_cnt); end
        report("goto 255 zero-step");
    endtask

    task automatic test_lock_loss();
        bit ok;
        bit seen;
        clear_mon();
        send_cmd(2'b01, 10'd5);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (psen_cnt == 2) begin seen = 1'b1; break; end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL lock_step2_wait: got psen=%0d want 2", psen_cnt); end
        @(posedge sys_clk); #1; dcm_locked = 1'b0;
        wait_done(10, ok);
        tests_run++; if (!ok || err !== 3'b100 || position !== 10'd0) begin tests_failed++; $display("FAIL lock_result: got done=%b err=%b pos=%0d want 1/100/0", ok, err, $signed(position)); end
        repeat (5) tick();
        tests_run++; if (cmd_ready !== 1'b0 || busy !== 1'b0 || done_cnt !== 1 || psen_cnt !== 2) begin tests_failed++; $display("FAIL lock_unlocked: got ready=%b busy=%b dones=%0d psen=%0d want 0/0/1/2", cmd_ready, busy, done_cnt, psen_cnt); end
        @(posedge sys_clk); #1; dcm_locked = 1'b1;
        tick();
        tests_run++; if (cmd_ready !== 1'b1 || position !== 10'd0) begin tests_failed++; $display("FAIL lock_relock: got ready=%b pos=%0d want 1/0", cmd_ready, $signed(position)); end
        report("dec 5 lock loss");
    endtask

    task automatic test_reset_mid_settle();
        bit seen;
        clear_mon();
        send_cmd(2'b00, 10'd2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (position == 10'd1) begin seen = 1'b1; break; end
        end
        tests_run++; if (!seen || busy !== 1'b1) begin tests_failed++; $display("FAIL rst_settle_wait: got seen=%b busy=%b want 1/1", seen, busy); end
        sys_rst_n = 1'b0;
        #1;
        tests_run++; if (position !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 3'b000) begin tests_failed++; $display("FAIL rst_settle_state: pos=%0d busy=%b done=%b err=%b want 0", $signed(position), busy, done, err); end
        tests_run++; if (dcm_psen !== 1'b0 || dcm_psincdec !== 1'b0 || cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_settle_outs: psen=%b incdec=%b ready=%b want 0/0/0", dcm_psen, dcm_psincdec, cmd_ready); end
        @(posedge sys_clk); #1; sys_rst_n = 1'b1;
        clear_mon();
        repeat (15) tick();
        tests_run++; if (psen_cnt !== 0 || cmd_ready !== 1'b1 || position !== 10'd0) begin tests_failed++; $display("FAIL rst_settle_after: psen=%0d ready=%b pos=%0d want 0/1/0", psen_cnt, cmd_ready, $signed(position)); end
        report("inc 2 reset mid-settle");
    endtask

    initial begin
        test_reset();
        test_inc();
        test_goto_neg();
        test_zero_op();
        test_clamp();
        test_timeout();
        test_zero_step();
        test_lock_loss();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
